// File: rtl/ipsxe_floating_point_axis_out_buffer_v1_0_if.sv
// -----------------------------------------------------------------------------
// ipsxe_floating_point_axis_out_buffer_v1_0_if
//
// Bundles the stream-facing signals of the floating-point output buffer.
// Signal names keep the buffer's point of view (i_* driven into the buffer,
// o_* driven by the buffer).
//
//   master : the buffer side (drives o_s_tready, o_issue, o_m_tvalid, o_m_tdata)
//   slave  : the surrounding logic (operand source, datapath, result sink)
//
// Signals:
//   i_s_tvalid / o_s_tready : operand handshake
//   o_issue                 : operand accepted this cycle (datapath enable)
//   i_result [N]            : datapath result
//   o_m_tvalid / i_m_tready : result handshake
//   o_m_tdata [N]           : result data, head of FIFO
//   i_s_tlast / o_m_tlast   : only when IPSXE_FLOATING_POINT_AXIS_TLAST_EN is defined
// -----------------------------------------------------------------------------
interface ipsxe_floating_point_axis_out_buffer_v1_0_if #(
    parameter int N = 64
);
    logic         i_s_tvalid;
    logic         o_s_tready;
    logic         o_issue;
    logic [N-1:0] i_result;
    logic         o_m_tvalid;
    logic         i_m_tready;
    logic [N-1:0] o_m_tdata;
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
    logic         i_s_tlast;
    logic         o_m_tlast;

    modport master (
        input  i_s_tvalid, i_result, i_m_tready, i_s_tlast,
        output o_s_tready, o_issue, o_m_tvalid, o_m_tdata, o_m_tlast
    );
    modport slave (
        output i_s_tvalid, i_result, i_m_tready, i_s_tlast,
        input  o_s_tready, o_issue, o_m_tvalid, o_m_tdata, o_m_tlast
    );
`else
    modport master (
        input  i_s_tvalid, i_result, i_m_tready,
        output o_s_tready, o_issue, o_m_tvalid, o_m_tdata
    );
    modport slave (
        output i_s_tvalid, i_result, i_m_tready,
        input  o_s_tready, o_issue, o_m_tvalid, o_m_tdata
    );
`endif
endinterface

// File: rtl/ipsxe_floating_point_axis_out_buffer_v1_0.sv
// -----------------------------------------------------------------------------
// ipsxe_floating_point_axis_out_buffer_v1_0
//
// Output buffer for a fixed-latency floating-point datapath. Operands are
// accepted on a valid/ready handshake and issued into the datapath; a
// LATENCY-deep valid delay line marks when each result appears on i_result;
// results are captured into a DEPTH-entry first-word-fall-through FIFO and
// presented on a valid/ready handshake with backpressure.
//
// An operand is only accepted while (in flight + buffered) < DEPTH, so every
// issued operation is guaranteed a FIFO slot when its result arrives and the
// datapath never needs to stall.
//
// Parameters:
//   N       : result width
//   LATENCY : register stages in the datapath (0 = combinational)
//   DEPTH   : FIFO entries (2..128); DEPTH >= LATENCY+2 sustains full rate
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_aclken : clock enable; all state holds while low
//   axis     : stream signals (see the interface file)
//
// Optional feature: define IPSXE_FLOATING_POINT_AXIS_TLAST_EN to carry a
// tlast bit alongside each operand through to o_m_tlast.
// -----------------------------------------------------------------------------
module ipsxe_floating_point_axis_out_buffer_v1_0 #(
    parameter int N       = 64,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_aclken,
    ipsxe_floating_point_axis_out_buffer_v1_0_if.master axis
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif

    logic [CW-1:0] inflight;
    logic [CW-1:0] occupancy;
    logic [CW:0]   credits_used;
    logic          s_tready;
    logic          issue;
    logic          wr_en;
    logic          wr_fire;
    logic          m_tvalid;
    logic          pop;
    logic [W-1:0]  wr_data;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  head;
    logic [W-1:0]  head_nxt;
    logic          head_load;
    logic [CW-1:0] occ_after_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready comes from registered counters only; i_rst forces it low during reset.
    assign credits_used = {1'b0, inflight} + {1'b0, occupancy};
    assign s_tready     = ~i_rst & (credits_used < (CW+1)'(DEPTH));
    assign issue        = axis.i_s_tvalid & s_tready & i_aclken;
    assign m_tvalid     = (occupancy != '0);
    assign pop          = m_tvalid & axis.i_m_tready & i_aclken;
    assign wr_fire      = wr_en & i_aclken;

    // -------------------------------------------------------------------------
    // Valid (and optional tlast) delay line matching the datapath latency
    // -------------------------------------------------------------------------
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
    logic wr_last;
    assign wr_data = {wr_last, axis.i_result};
`else
    assign wr_data = axis.i_result;
`endif

    generate
        if (LATENCY == 0) begin : g_comb
            assign wr_en = issue;
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
            assign wr_last = axis.i_s_tlast;
`endif
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_sr;
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
            logic [LATENCY-1:0] last_sr;
`endif
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    vld_sr <= '0;
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
                    last_sr <= '0;
`endif
                end else if (i_aclken) begin
                    vld_sr <= (vld_sr << 1) | LATENCY'(issue);
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
                    last_sr <= (last_sr << 1) | LATENCY'(issue & axis.i_s_tlast);
`endif
                end
            end
            assign wr_en = vld_sr[LATENCY-1];
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
            assign wr_last = last_sr[LATENCY-1];
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy and pointers decide which
    // entries are meaningful, and leaving it out keeps it mappable to RAM.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Registered head: reload when the FIFO goes from empty to non-empty
    // (bypass the incoming result) or when a pop exposes the next entry.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        head_nxt      = head;
        head_load     = 1'b0;
        occ_after_pop = occupancy - CW'(pop);
        if (wr_fire && occ_after_pop == '0) begin
            head_nxt  = wr_data;
            head_load = 1'b1;
        end else if (pop && occ_after_pop != '0) begin
            head_nxt  = mem[next_ptr(rd_ptr)];
            head_load = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight  <= '0;
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head      <= '0;
        end else if (i_aclken) begin
            inflight  <= inflight + CW'(issue) - CW'(wr_en);
            occupancy <= occupancy + CW'(wr_en) - CW'(pop);
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (head_load) begin
                head <= head_nxt;
            end
        end
    end

    assign axis.o_s_tready = s_tready;
    assign axis.o_issue    = issue;
    assign axis.o_m_tvalid = m_tvalid;
    assign axis.o_m_tdata  = head[N-1:0];
`ifdef IPSXE_FLOATING_POINT_AXIS_TLAST_EN
    assign axis.o_m_tlast  = head[N];
`endif

`ifndef SYNTHESIS
    // Credit accounting makes a write into a full FIFO unreachable.
    no_overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
        !(wr_fire && occupancy == CW'(DEPTH)));
`endif

endmodule

// File: doc/ipsxe_floating_point_axis_out_buffer_v1_0.md
Name: ipsxe_floating_point_axis_out_buffer_v1_0

Overview:
Sits directly downstream of the floating-point datapath, whose internal pipeline registers are inserted or omitted per the latency configuration. It does three things:
- Accepts operands on an AXI-Stream-style slave handshake and issues them into the fixed-latency datapath.
- Tracks issued operations through a LATENCY-deep valid delay line.
- Captures results into a DEPTH-entry FIFO and presents them on an AXI-Stream master handshake with backpressure.

Credit accounting guarantees no result is ever dropped, so the datapath itself needs no stall logic.

Parameters:
N, 64, result data width in bits.
LATENCY, 4, number of register stages actually instantiated in the datapath (0..64); 0 means the datapath is combinational.
DEPTH, 8, result FIFO entries; legal range 2..128. Full throughput requires DEPTH >= LATENCY+2.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous active-high reset.
i_aclken  input  1  clock enable; when low, all state in the block holds.
i_s_tvalid  input  1  upstream operand valid.
o_s_tready  output  1  block can accept an operand.
o_issue  output  1  operand accepted this cycle; drives the datapath's valid/enable.
i_result  input  N  datapath result.
o_m_tvalid  output  1  result available.
i_m_tready  input  1  downstream accepts the result.
o_m_tdata  output  N  result data, head of FIFO.

Behaviour:
Reset:
- Asynchronous; clears the delay line, FIFO pointers, occupancy and in-flight counters.
- o_m_tvalid=0, o_s_tready=0, o_issue=0, o_m_tdata=0 while i_rst is high.
- o_s_tready=1 from the first cycle after release.
- Reset mid-operation discards all in-flight and buffered results; datapath contents are don't-care because their valids are cleared.

Issue:
- o_issue = i_s_tvalid & o_s_tready & i_aclken.

Credits:
- credits_used = inflight + occupancy, each ceil(log2(DEPTH+1)) bits wide.
- o_s_tready = (credits_used < DEPTH). It depends only on registered state; there is no combinational path from i_m_tready to o_s_tready.

Delay line:
- LATENCY-bit shift register, gated by i_aclken, whose input is o_issue.
- wr_en = last stage of the delay line; for LATENCY=0, wr_en = o_issue.
- An operand accepted at edge k is written into the FIFO at edge k+LATENCY, counted in i_aclken-high edges.
- At the write edge, inflight decrements and occupancy increments.
- The inflight counter equals the popcount of the delay line and may be implemented either way.

FIFO:
- Circular buffer with pointers wrapping DEPTH-1 -> 0; non-power-of-two DEPTH must be supported.
- First-word fall-through: o_m_tvalid = (occupancy != 0); o_m_tdata = mem[rd_ptr], registered.
- Pop = o_m_tvalid & i_m_tready & i_aclken.

Simultaneous events:
- Issue + write + pop in one edge: all applied; net credits_used change = issue - pop.
- Write and pop with occupancy == 0 cannot occur, because o_m_tvalid is low.
- Write while occupancy == DEPTH is impossible by construction. The FIFO asserts on it in simulation only.

Clock enable:
- i_aclken=0 freezes every register.
- No handshake completes while i_aclken=0, even if both valid and ready are high.
- Outputs hold their values.

Optional Feature:
Macro: IPSXE_FLOATING_POINT_AXIS_TLAST_EN.
- Defined: adds input i_s_tlast and output o_m_tlast. tlast is carried through a LATENCY-deep shift register alongside the valid bit and stored as an extra FIFO bit (N+1 wide). o_m_tlast is aligned with o_m_tdata; reset value 0.
- Undefined: neither port exists and the FIFO is N bits wide.

Test Plan:
- Reset, then stream: LATENCY=4, DEPTH=8, i_m_tready=1, 20 back-to-back operands with i_result = operand index. Required: o_m_tvalid first high exactly 4 edges after the first accept; data 0..19 in order; o_s_tready never drops.
- Backpressure fill: i_m_tready=0, i_s_tvalid=1 continuous. Required: exactly 8 accepts, then o_s_tready=0. Then i_m_tready=1: 8 results out in order, and o_s_tready returns high the edge after the first pop.
- LATENCY=0, DEPTH=2 combinational datapath: an operand accepted at edge k gives o_m_tvalid high after edge k with matching data. Alternating i_m_tready produces no loss or duplication.
- Clock enable: toggle i_aclken 1,0,0,1 during streaming, with valid and ready high throughout. Required: no transfers on the i_aclken=0 cycles; total accepted equals total delivered.
- Reset mid-operation: assert i_rst with 3 results in flight and 2 buffered. Required: o_m_tvalid=0 immediately (asynchronous); after release, no stale result ever emerges and o_s_tready=1.
- TLAST_EN defined: set tlast on operand 5 of 8. Required: o_m_tlast high only with the 5th output beat, under random i_m_tready.
